// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU control FSM: state codes, instruction fields,
// register/writeback selects and the packed control-output vector.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RST       = 4'd0,
      S_IF1       = 4'd1,
      S_IF2       = 4'd2,
      S_UPDATEPC  = 4'd3,
      S_DECODE    = 4'd4,
      S_WRITE_IMM = 4'd5,
      S_GET_A     = 4'd6,
      S_GET_B     = 4'd7,
      S_EXEC      = 4'd8,
      S_WRITE_RD  = 4'd9,
      S_ADDR      = 4'd10,
      S_MEM_RD1   = 4'd11,
      S_MEM_RD2   = 4'd12,
      S_GET_B_ST  = 4'd13,
      S_STORE     = 4'd14,
      S_HALT      = 4'd15
   } state_e;

   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_HALT = 3'b111;

   localparam logic [1:0] OP_MOVREG = 2'b00;
   localparam logic [1:0] OP_CMP    = 2'b01;
   localparam logic [1:0] OP_MOVIMM = 2'b10;
   localparam logic [1:0] OP_MEM    = 2'b00;

   localparam logic [2:0] NSEL_NONE = 3'b000;
   localparam logic [2:0] NSEL_RN   = 3'b001;
   localparam logic [2:0] NSEL_RD   = 3'b010;
   localparam logic [2:0] NSEL_RM   = 3'b100;

   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_IMM   = 2'b10;
   localparam logic [1:0] VSEL_MDATA = 2'b11;

   typedef struct packed {
      logic       pcreset;
      logic       loadpc;
      logic       msel;
      logic       loadir;
      logic       mwrite;
      logic [2:0] nsel;
      logic [1:0] vsel;
      logic       write;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic       halted;
   } ctrl_out_t;

endpackage

// File: rtl/cpu_controller_outdec.sv
// Combinational state-to-control decode. The opcode/op fields only shape the
// EXEC strobes; ir is held stable by the fetch logic while EXEC is active.
module ctrl_outdec
   import cpu_ctrl_pkg::*;
(
   input  state_e     state_i,
   input  logic [2:0] opcode_i,
   input  logic [1:0] op_i,
   output ctrl_out_t  out_o
);

   always_comb begin
      out_o = '0;
      case (state_i)
         S_RST:       out_o.pcreset = 1'b1;
         S_IF1:       out_o.msel    = 1'b0;
         S_IF2:       out_o.loadir  = 1'b1;
         S_UPDATEPC:  out_o.loadpc  = 1'b1;
         S_DECODE:    out_o.nsel    = NSEL_NONE;
         S_WRITE_IMM: begin
            out_o.nsel  = NSEL_RN;
            out_o.vsel  = VSEL_IMM;
            out_o.write = 1'b1;
         end
         S_GET_A: begin
            out_o.nsel  = NSEL_RN;
            out_o.loada = 1'b1;
         end
         S_GET_B: begin
            out_o.nsel  = NSEL_RM;
            out_o.loadb = 1'b1;
         end
         S_EXEC: begin
            out_o.loadc = 1'b1;
            out_o.asel  = (opcode_i == OPC_MOV) && (op_i == OP_MOVREG);
            out_o.loads = (op_i == OP_CMP);
         end
         S_WRITE_RD: begin
            out_o.nsel  = NSEL_RD;
            out_o.vsel  = VSEL_C;
            out_o.write = 1'b1;
         end
         S_ADDR: begin
            out_o.bsel  = 1'b1;
            out_o.loadc = 1'b1;
         end
         S_MEM_RD1:   out_o.msel = 1'b1;
         S_MEM_RD2: begin
            out_o.msel  = 1'b1;
            out_o.nsel  = NSEL_RD;
            out_o.vsel  = VSEL_MDATA;
            out_o.write = 1'b1;
         end
         S_GET_B_ST: begin
            out_o.nsel  = NSEL_RD;
            out_o.loadb = 1'b1;
         end
         S_STORE: begin
            out_o.msel   = 1'b1;
            out_o.mwrite = 1'b1;
         end
         S_HALT:      out_o.halted = 1'b1;
         default:     out_o = '0;
      endcase
   end

endmodule

// File: rtl/cpu_controller.sv
// Moore control FSM for the simple 16-bit CPU: fetch, decode, execute and
// memory sequencing. State register and next-state logic live here.
module cpu_controller
   import cpu_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] ir,
   output logic        pcreset,
   output logic        loadpc,
   output logic        msel,
   output logic        loadir,
   output logic        mwrite,
   output logic [2:0]  nsel,
   output logic [1:0]  vsel,
   output logic        write,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel,
   output logic        halted
);

   state_e     state_q, state_d;
   ctrl_out_t  ctrl;
   logic [2:0] opcode;
   logic [1:0] op;
   logic       is_movimm, is_movreg, is_alu, is_cmp, is_ldr, is_str, is_halt;
   logic       unused_ir_bits;

   assign opcode         = ir[15:13];
   assign op             = ir[12:11];
   assign unused_ir_bits = ^ir[10:0];

   assign is_movimm = (opcode == OPC_MOV) && (op == OP_MOVIMM);
   assign is_movreg = (opcode == OPC_MOV) && (op == OP_MOVREG);
   assign is_alu    = (opcode == OPC_ALU);
   assign is_cmp    = is_alu && (op == OP_CMP);
   assign is_ldr    = (opcode == OPC_LDR) && (op == OP_MEM);
   assign is_str    = (opcode == OPC_STR) && (op == OP_MEM);
   assign is_halt   = (opcode == OPC_HALT);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST:      state_d = S_IF1;
         S_IF1:      state_d = S_IF2;
         S_IF2:      state_d = S_UPDATEPC;
         S_UPDATEPC: state_d = S_DECODE;
         S_DECODE: begin
            // Unrecognised encodings fall straight back to fetch as a NOP.
            state_d = S_IF1;
            if (is_movimm)
               state_d = S_WRITE_IMM;
            else if (is_movreg || is_alu || is_ldr || is_str)
               state_d = S_GET_A;
            else if (is_halt)
               state_d = S_HALT;
         end
         S_WRITE_IMM: state_d = S_IF1;
         S_GET_A:     state_d = (is_ldr || is_str) ? S_ADDR : S_GET_B;
         S_GET_B:     state_d = S_EXEC;
         S_EXEC:      state_d = is_cmp ? S_IF1 : S_WRITE_RD;
         S_WRITE_RD:  state_d = S_IF1;
         S_ADDR:      state_d = is_ldr ? S_MEM_RD1 : S_GET_B_ST;
         S_MEM_RD1:   state_d = S_MEM_RD2;
         S_MEM_RD2:   state_d = S_IF1;
         S_GET_B_ST:  state_d = S_STORE;
         S_STORE:     state_d = S_IF1;
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_RST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= S_RST;
      else
         state_q <= state_d;
   end

   ctrl_outdec u_outdec (
      .state_i  (state_q),
      .opcode_i (opcode),
      .op_i     (op),
      .out_o    (ctrl)
   );

   assign pcreset = ctrl.pcreset;
   assign loadpc  = ctrl.loadpc;
   assign msel    = ctrl.msel;
   assign loadir  = ctrl.loadir;
   assign mwrite  = ctrl.mwrite;
   assign nsel    = ctrl.nsel;
   assign vsel    = ctrl.vsel;
   assign write   = ctrl.write;
   assign loada   = ctrl.loada;
   assign loadb   = ctrl.loadb;
   assign loadc   = ctrl.loadc;
   assign loads   = ctrl.loads;
   assign asel    = ctrl.asel;
   assign bsel    = ctrl.bsel;
   assign halted  = ctrl.halted;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: an instruction-level model queues the
// expected per-cycle control vector, and a negedge monitor pops and compares.
module tb_cpu_controller;

   typedef struct packed {
      logic       pcreset;
      logic       loadpc;
      logic       msel;
      logic       loadir;
      logic       mwrite;
      logic [2:0] nsel;
      logic [1:0] vsel;
      logic       write;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic       halted;
   } ov_t;

   typedef struct {
      ov_t   v;
      string tag;
   } exp_t;

   bit          clk;
   logic        reset;
   logic [15:0] ir;
   logic        pcreset, loadpc, msel, loadir, mwrite, write;
   logic        loada, loadb, loadc, loads, asel, bsel, halted;
   logic [2:0]  nsel;
   logic [1:0]  vsel;
   ov_t         act;

   exp_t sb[$];
   exp_t plan[$];
   int   tests = 0;
   int   fails = 0;
   bit   finish_req = 1'b0;
   bit   end_checked = 1'b0;

   cpu_controller dut (
      .clk     (clk),
      .reset   (reset),
      .ir      (ir),
      .pcreset (pcreset),
      .loadpc  (loadpc),
      .msel    (msel),
      .loadir  (loadir),
      .mwrite  (mwrite),
      .nsel    (nsel),
      .vsel    (vsel),
      .write   (write),
      .loada   (loada),
      .loadb   (loadb),
      .loadc   (loadc),
      .loads   (loads),
      .asel    (asel),
      .bsel    (bsel),
      .halted  (halted)
   );

   always #5 clk = ~clk;

   assign act = {pcreset, loadpc, msel, loadir, mwrite, nsel, vsel, write,
                 loada, loadb, loadc, loads, asel, bsel, halted};

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         tests++;
         if (act !== e.v) begin
            fails++;
            $display("FAIL %s: got %b want %b", e.tag, act, e.v);
         end
         tests++;
         if (mwrite === 1'b1 && write === 1'b1) begin
            fails++;
            $display("FAIL excl_%s: got mwrite=1 write=1 want not both", e.tag);
         end
      end else if (finish_req && !end_checked) begin
         end_checked = 1'b1;
         tests++;
         if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
         end
      end
   end

   task automatic add(input ov_t v, input string tag);
      exp_t e;
      e.v   = v;
      e.tag = tag;
      plan.push_back(e);
   endtask

   // Instruction-level reference: one entry per cycle from IF1 to the last
   // cycle before the next IF1 (HALT repeated halt_hold times).
   task automatic plan_instr(input logic [15:0] i, input int unsigned halt_hold);
      logic [2:0] opc;
      logic [1:0] op;
      ov_t        v;
      plan.delete();
      opc = i[15:13];
      op  = i[12:11];
      v = '0;                                    add(v, "IF1");
      v = '0; v.loadir = 1'b1;                   add(v, "IF2");
      v = '0; v.loadpc = 1'b1;                   add(v, "UPDATEPC");
      v = '0;                                    add(v, "DECODE");
      if (opc == 3'b110 && op == 2'b10) begin
         v = '0; v.nsel = 3'b001; v.vsel = 2'b10; v.write = 1'b1;
         add(v, "WRITE_IMM");
      end else if (opc == 3'b101 || (opc == 3'b110 && op == 2'b00)) begin
         v = '0; v.nsel = 3'b001; v.loada = 1'b1; add(v, "GET_A");
         v = '0; v.nsel = 3'b100; v.loadb = 1'b1; add(v, "GET_B");
         v = '0; v.loadc = 1'b1;
         v.asel  = (opc == 3'b110);
         v.loads = (opc == 3'b101 && op == 2'b01);
         add(v, "EXEC");
         if (!(opc == 3'b101 && op == 2'b01)) begin
            v = '0; v.nsel = 3'b010; v.vsel = 2'b00; v.write = 1'b1;
            add(v, "WRITE_RD");
         end
      end else if ((opc == 3'b011 || opc == 3'b100) && op == 2'b00) begin
         v = '0; v.nsel = 3'b001; v.loada = 1'b1; add(v, "GET_A");
         v = '0; v.bsel = 1'b1; v.loadc = 1'b1;   add(v, "ADDR");
         if (opc == 3'b011) begin
            v = '0; v.msel = 1'b1;                add(v, "MEM_RD1");
            v = '0; v.msel = 1'b1; v.nsel = 3'b010; v.vsel = 2'b11; v.write = 1'b1;
            add(v, "MEM_RD2");
         end else begin
            v = '0; v.nsel = 3'b010; v.loadb = 1'b1; add(v, "GET_B_ST");
            v = '0; v.msel = 1'b1; v.mwrite = 1'b1;  add(v, "STORE");
         end
      end else if (opc == 3'b111) begin
         for (int unsigned k = 0; k < halt_hold; k++) begin
            v = '0; v.halted = 1'b1; add(v, "HALT");
         end
      end
   endtask

   // Entered 1ns after the edge preceding IF1; leaves at the same phase of the
   // last planned cycle. ir changes only after the edge that enters IF1.
   task automatic issue(input logic [15:0] i, input int unsigned cut);
      int unsigned n;
      n = plan.size();
      if (cut != 0 && cut < n) n = cut;
      for (int unsigned k = 0; k < n; k++) sb.push_back(plan[k]);
      @(posedge clk);
      #1 ir = i;
      repeat (n - 1) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int unsigned n);
      exp_t e;
      e.v = '0;
      e.v.pcreset = 1'b1;
      e.tag = "RST";
      reset = 1'b1;
      for (int unsigned k = 0; k < n; k++) sb.push_back(e);
      repeat (n) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic run(input logic [15:0] i, input int unsigned hold, input int unsigned cut);
      plan_instr(i, hold);
      issue(i, cut);
   endtask

   initial begin
      ir    = 16'h0000;
      reset = 1'b1;
      do_reset(3);

      run(16'hD105, 0, 0);
      run(16'hA0A1, 0, 0);
      run(16'hA800, 0, 0);
      run(16'hC000, 0, 0);
      run(16'h8000, 0, 0);
      run(16'h6000, 0, 0);
      run(16'h0000, 0, 0);
      run(16'hE000, 20, 0);
      do_reset(2);
      run(16'h6000, 0, 7);
      do_reset(2);

      for (int t = 0; t < 120; t++) begin
         logic [15:0] r;
         int unsigned full;
         r = 16'($urandom);
         plan_instr(r, $urandom_range(1, 6));
         full = plan.size();
         if (r[15:13] == 3'b111) begin
            issue(r, 0);
            do_reset($urandom_range(1, 3));
         end else if ($urandom_range(0, 9) == 0) begin
            issue(r, $urandom_range(1, full));
            do_reset($urandom_range(1, 3));
         end else begin
            issue(r, 0);
         end
      end

      repeat (2) @(posedge clk);
      finish_req = 1'b1;
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
